// File: rtl/serial_cmp_pkg.sv
// Shared types for the LSB-first bit-serial comparator: FSM states, the
// running verdict encoding and the cascade-seed decoder.
package serial_cmp_pkg;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   typedef enum logic [1:0] {V_LT, V_EQ, V_GT} verdict_t;

   // Priority l > g > e; all-zero and multi-hot seeds fall through safely.
   function automatic verdict_t seed_decode(input logic l, input logic g, input logic e);
      verdict_t v;
      v = V_EQ;
      if (l)      v = V_LT;
      else if (g) v = V_GT;
      else if (e) v = V_EQ;
      return v;
   endfunction

endpackage

// File: rtl/serial_comparator_lsb_bit_step.sv
// One bit of the LSB-first scan: a differing bit overrides the running verdict,
// equal bits leave it untouched.
module serial_comparator_lsb_bit_step
   import serial_cmp_pkg::*;
(
   input  logic     a_bit,
   input  logic     b_bit,
   input  verdict_t verdict_in,
   output verdict_t verdict_out
);

   always_comb begin
      verdict_out = verdict_in;
      if (a_bit && !b_bit)      verdict_out = V_GT;
      else if (!a_bit && b_bit) verdict_out = V_LT;
   end

endmodule

// File: rtl/serial_comparator_lsb.sv
// Bit-serial magnitude comparator scanning LSB-first with a cascade seed.
// Handshake: a side transfers when valid && ready are both high on a rising edge.
module serial_comparator_lsb
   import serial_cmp_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             l,
   input  logic             g,
   input  logic             e,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   verdict_t           verdict_q, verdict_d;
   verdict_t           step_v;
   logic               out_valid_q, out_valid_d;
   logic               lt_q, lt_d;
   logic               eq_q, eq_d;
   logic               gt_q, gt_d;

   serial_comparator_lsb_bit_step u_bit_step (
      .a_bit       (a_sh_q[0]),
      .b_bit       (b_sh_q[0]),
      .verdict_in  (verdict_q),
      .verdict_out (step_v)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      verdict_d   = verdict_q;
      out_valid_d = out_valid_q;
      lt_d        = lt_q;
      eq_d        = eq_q;
      gt_d        = gt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sh_d    = a;
               b_sh_d    = b;
               verdict_d = seed_decode(l, g, e);
               cnt_d     = '0;
               state_d   = S_SCAN;
            end
         end
         S_SCAN: begin
            a_sh_d    = a_sh_q >> 1;
            b_sh_d    = b_sh_q >> 1;
            verdict_d = step_v;
            cnt_d     = cnt_q + CNT_W'(1);
            // The bit examined on this cycle is the MSB: publish the verdict.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d       = '0;
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               lt_d        = (step_v == V_LT);
               eq_d        = (step_v == V_EQ);
               gt_d        = (step_v == V_GT);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         verdict_q   <= V_EQ;
         out_valid_q <= 1'b0;
         lt_q        <= 1'b0;
         eq_q        <= 1'b1;
         gt_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         verdict_q   <= verdict_d;
         out_valid_q <= out_valid_d;
         lt_q        <= lt_d;
         eq_q        <= eq_d;
         gt_q        <= gt_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign lt        = lt_q;
   assign eq        = eq_q;
   assign gt        = gt_q;

endmodule

// File: tb/tb_serial_comparator_lsb.sv
// Bench for serial_comparator_lsb: directed cases on an 8-bit instance, then
// randomized regressions on 8- and 16-bit instances against a reference compare.
module tb_serial_comparator_lsb;

   logic        clk;
   logic        rst_n;
   logic        in_valid  [2];
   logic        out_ready [2];
   logic [15:0] a_s       [2];
   logic [15:0] b_s       [2];
   logic        l_s       [2];
   logic        g_s       [2];
   logic        e_s       [2];
   logic        in_ready  [2];
   logic        out_valid [2];
   logic        lt        [2];
   logic        eq        [2];
   logic        gt        [2];

   int n_checks;
   int n_pass;
   logic [2:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   serial_comparator_lsb #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a_s[0][7:0]), .b(b_s[0][7:0]),
      .l(l_s[0]), .g(g_s[0]), .e(e_s[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .lt(lt[0]), .eq(eq[0]), .gt(gt[0])
   );

   serial_comparator_lsb #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a_s[1]), .b(b_s[1]),
      .l(l_s[1]), .g(g_s[1]), .e(e_s[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .lt(lt[1]), .eq(eq[1]), .gt(gt[1])
   );

   // ---------------- checking / reference ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic int width_of(input int d);
      return (d == 0) ? 8 : 16;
   endfunction

   // Seed acts as a 1-bit lower word: {a,sa} vs {b,sb}. Result is {lt,eq,gt}.
   function automatic logic [2:0] ref_verdict(input logic [15:0] av, input logic [15:0] bv,
                                              input logic sl, input logic sg);
      int unsigned wa, wb;
      int unsigned sa, sb;
      if (sl)      begin sa = 0; sb = 1; end
      else if (sg) begin sa = 1; sb = 0; end
      else         begin sa = 0; sb = 0; end
      wa = 2 * int'(av) + sa;
      wb = 2 * int'(bv) + sb;
      if (wa < wb) return 3'b100;
      if (wa > wb) return 3'b001;
      return 3'b010;
   endfunction

   // ---------------- driver ----------------
   task automatic do_txn(input int d, input logic [15:0] av_in, input logic [15:0] bv_in,
                         input logic sl, input logic sg, input logic se,
                         input int gap, input int stall);
      logic [15:0] av, bv;
      logic [2:0]  held;
      int          cyc;
      av = (d == 0) ? (av_in & 16'h00FF) : av_in;
      bv = (d == 0) ? (bv_in & 16'h00FF) : bv_in;
      exp_q.push_back(ref_verdict(av, bv, sl, sg));
      repeat (gap) @(negedge clk);
      a_s[d] = av; b_s[d] = bv; l_s[d] = sl; g_s[d] = sg; e_s[d] = se;
      in_valid[d] = 1'b1;
      check("in_ready_idle", in_ready[d], 1);
      @(posedge clk);
      @(negedge clk);
      in_valid[d] = 1'b0;
      a_s[d] = 16'($urandom); b_s[d] = 16'($urandom);
      l_s[d] = 1'($urandom); g_s[d] = 1'($urandom); e_s[d] = 1'($urandom);
      check("in_ready_scan", in_ready[d], 0);
      cyc = 1;
      while (!out_valid[d] && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("latency", cyc, width_of(d) + 1);
      held = {lt[d], eq[d], gt[d]};
      check("result", held, exp_q.pop_front());
      check("onehot", $countones(held), 1);
      repeat (stall) begin
         in_valid[d] = 1'($urandom);
         @(negedge clk);
         check("hold_valid", out_valid[d], 1);
         check("hold_result", {lt[d], eq[d], gt[d]}, held);
         check("hold_in_ready", in_ready[d], 0);
      end
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
      in_valid[d]  = 1'b0;
      check("release_valid", out_valid[d], 0);
      check("release_in_ready", in_ready[d], 1);
      check("idle_keeps_result", {lt[d], eq[d], gt[d]}, held);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; out_ready[d] = 1'b0;
         a_s[d] = '0; b_s[d] = '0; l_s[d] = 1'b0; g_s[d] = 1'b0; e_s[d] = 1'b0;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         check("reset_out_valid", out_valid[d], 0);
         check("reset_in_ready", in_ready[d], 1);
         check("reset_result", {lt[d], eq[d], gt[d]}, 3'b010);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_txn(0, 16'h05, 16'h03, 1'b0, 1'b0, 1'b1, 0, 0);
      do_txn(0, 16'h80, 16'h7F, 1'b1, 1'b0, 1'b0, 0, 1);
      do_txn(0, 16'hA5, 16'hA5, 1'b1, 1'b0, 1'b0, 0, 0);
      do_txn(0, 16'hA5, 16'hA5, 1'b0, 1'b1, 1'b0, 0, 0);
      do_txn(0, 16'hA5, 16'hA5, 1'b0, 1'b0, 1'b1, 0, 0);
      do_txn(0, 16'hA5, 16'hA5, 1'b0, 1'b0, 1'b0, 0, 0);
      do_txn(0, 16'hA5, 16'hA5, 1'b1, 1'b1, 1'b0, 0, 0);
      do_txn(0, 16'h01, 16'h02, 1'b0, 1'b0, 1'b1, 1, 5);
      do_txn(0, 16'h03, 16'h01, 1'b0, 1'b0, 1'b1, 0, 0);

      // Reset during the 4th SCAN cycle; prior result was gt.
      a_s[0] = 16'h55; b_s[0] = 16'hAA; l_s[0] = 1'b0; g_s[0] = 1'b0; e_s[0] = 1'b1;
      in_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_out_valid", out_valid[0], 0);
      #1 rst_n = 1'b0;
      #1;
      check("midscan_reset_out_valid", out_valid[0], 0);
      check("midscan_reset_in_ready", in_ready[0], 1);
      check("midscan_reset_result", {lt[0], eq[0], gt[0]}, 3'b010);
      @(negedge clk);
      rst_n = 1'b1;
      check("post_reset_out_valid", out_valid[0], 0);
      do_txn(0, 16'h10, 16'h10, 1'b0, 1'b0, 1'b1, 1, 0);

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            do_txn(d, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
